fallthrough_fifo: RTL and testbench
===================================

Name: fallthrough_fifo

Overview:
- Small synchronous first-word-fall-through FIFO built from a register array.
- Used as the input buffer of packet-pipeline stages, for example the TCP-tuple parser that stores {ctrl, data} words (72 bits).
- The head word is always presented on dout while the FIFO is not empty.
- The consumer inspects dout and pops it with rd_en in the same cycle, with no read latency.

Parameters:
- WIDTH, 72, width in bits of each stored word.
- MAX_DEPTH_BITS, 3, log2 of the depth; DEPTH = 2**MAX_DEPTH_BITS (8 by default).
- NEARLY_FULL, 2**MAX_DEPTH_BITS - 1, occupancy at or above which nearly_full is asserted.

Ports:
- clk  input  1  single clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- din  input  WIDTH  write data.
- wr_en  input  1  write strobe; din is captured on the rising edge.
- rd_en  input  1  pop strobe; removes the current head word on the rising edge.
- dout  output  WIDTH  current head word, combinational from storage.
- full  output  1  occupancy == DEPTH.
- nearly_full  output  1  occupancy >= NEARLY_FULL.
- empty  output  1  occupancy == 0.

Behaviour:
- Storage:
  - DEPTH x WIDTH register array.
  - Write pointer and read pointer, each MAX_DEPTH_BITS wide, wrapping modulo DEPTH.
  - Occupancy counter, MAX_DEPTH_BITS+1 wide, range 0..DEPTH.
- Reset (asynchronous, takes effect immediately, any cycle including mid-transfer):
  - Pointers = 0, count = 0.
  - empty = 1, full = 0, nearly_full = 0.
  - Array contents are not cleared; dout is don't-care while empty.
- Write: if wr_en and (not full or rd_en), din is stored at wr_ptr and wr_ptr increments.
- Read: if rd_en and not empty, rd_ptr increments.
- Count update:
  - +1 on an accepted write only.
  - -1 on an accepted read only.
  - Unchanged when both are accepted in the same cycle.
- Fall-through timing:
  - dout = mem[rd_ptr] combinationally.
  - A word written into an empty FIFO appears on dout, with empty = 0, in the cycle after the write edge. Write-to-visible latency is 1 clock.
  - After a pop, the next word is on dout in the following cycle.
- Boundary conditions:
  - Write while full without rd_en: ignored; no state change, data dropped.
  - Write while full with rd_en: both accepted; count stays DEPTH; the oldest word is replaced in sequence order.
  - Read while empty: ignored; pointers and count unchanged.
  - Read and write together while empty: only the write is accepted; count becomes 1.
- Flags are registered-state derived (decoded from count) and update in the same edge as count; there is no combinational path from wr_en/rd_en to flags.
- Ordering is strictly FIFO; no word is duplicated or skipped across pointer wrap-around.

Optional Feature:
- Macro: FIFO_ERR_CHECK_EN.
- When defined:
  - A simulation-only check prints an error message, with the simulation time, on any write while full without a same-cycle read.
  - It does the same on any read while empty.
  - The ignored operation behaves exactly as in the boundary rules above.
  - The check is excluded from synthesis.
- When undefined: illegal operations are silently ignored, and the RTL is identical except that the checker is absent.

Decomposition:
- No shared package; the only constant is DEPTH, a localparam derived from MAX_DEPTH_BITS.
- One natural sub-module: fifo_regfile. It is the DEPTH x WIDTH register array with synchronous write port and asynchronous read port.
- The pointer, count and flag logic stays in fallthrough_fifo.

Test Plan:
- Reset, then idle: empty = 1, full = 0, nearly_full = 0. Assert reset mid-stream with 3 words stored: empty = 1 immediately, before the next clock edge.
- Write 0x00_00AA in one cycle: the next cycle gives empty = 0 and dout = 0x00_00AA. Pop it: the following cycle gives empty = 1.
- Write 8 words 0x01..0x08 back-to-back:
  - nearly_full rises after the 7th write; full rises after the 8th.
  - A 9th write of 0x09 is ignored.
  - Popping 8 words yields 0x01..0x08 in order, then empty = 1.
- Fill to 8, then assert wr_en = rd_en = 1 with din = 0x10: the count stays 8, full stays 1, and the popped word is 0x01; the head is then 0x02.
- On an empty FIFO, assert rd_en = wr_en = 1 with din = 0x20: the count becomes 1 and dout = 0x20. Assert rd_en alone on an empty FIFO: no change. With FIFO_ERR_CHECK_EN defined, exactly one error message is printed for the rd_en-alone case.
- Stream 20 words with random wr_en/rd_en: the output sequence equals the accepted input sequence across pointer wraps, and the flags match a reference count at every cycle.

Source files
------------

// File: rtl/fifo_regfile.sv
// DEPTH x WIDTH storage array for fallthrough_fifo: one synchronous write port,
// one asynchronous read port so the head word is visible without read latency.
module fifo_regfile #(
    parameter int WIDTH     = 72,
    parameter int ADDR_BITS = 3
) (
    input  logic                 clk,
    input  logic                 wr_en,
    input  logic [ADDR_BITS-1:0] wr_addr,
    input  logic [WIDTH-1:0]     wr_data,
    input  logic [ADDR_BITS-1:0] rd_addr,
    output logic [WIDTH-1:0]     rd_data
);

    localparam int DEPTH = 2 ** ADDR_BITS;

    logic [WIDTH-1:0] mem [DEPTH];

    // Data storage carries no reset; contents are only meaningful when counted valid.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/fallthrough_fifo.sv
// First-word-fall-through FIFO: head word is driven on dout whenever not empty.
// Optional simulation-only misuse checker enabled by defining FIFO_ERR_CHECK_EN.
module fallthrough_fifo #(
    parameter int WIDTH          = 72,
    parameter int MAX_DEPTH_BITS = 3,
    parameter int NEARLY_FULL    = 2 ** MAX_DEPTH_BITS - 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    input  logic             wr_en,
    input  logic             rd_en,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             nearly_full,
    output logic             empty
);

    localparam int DEPTH = 2 ** MAX_DEPTH_BITS;
    localparam logic [MAX_DEPTH_BITS:0] DEPTH_CNT = (MAX_DEPTH_BITS + 1)'(DEPTH);
    localparam logic [MAX_DEPTH_BITS:0] NF_CNT    = (MAX_DEPTH_BITS + 1)'(NEARLY_FULL);

    logic [MAX_DEPTH_BITS-1:0] wr_ptr;
    logic [MAX_DEPTH_BITS-1:0] rd_ptr;
    logic [MAX_DEPTH_BITS:0]   count;
    logic                      wr_accept;
    logic                      rd_accept;

    // A write into a full FIFO is legal when the head is popped in the same cycle.
    assign wr_accept = wr_en && (!full || rd_en);
    assign rd_accept = rd_en && !empty;

    fifo_regfile #(
        .WIDTH    (WIDTH),
        .ADDR_BITS(MAX_DEPTH_BITS)
    ) u_regfile (
        .clk    (clk),
        .wr_en  (wr_accept),
        .wr_addr(wr_ptr),
        .wr_data(din),
        .rd_addr(rd_ptr),
        .rd_data(dout)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_accept) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_accept) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (wr_accept && !rd_accept) begin
                count <= count + 1'b1;
            end else if (rd_accept && !wr_accept) begin
                count <= count - 1'b1;
            end
        end
    end

    // Flags decode only the registered count, so they never depend on this cycle's strobes.
    assign full        = (count == DEPTH_CNT);
    assign nearly_full = (count >= NF_CNT);
    assign empty       = (count == '0);

`ifdef FIFO_ERR_CHECK_EN
`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (!reset) begin
            if (wr_en && full && !rd_en) begin
                $display("%0t: fallthrough_fifo error: write while full ignored", $time);
            end
            if (rd_en && empty) begin
                $display("%0t: fallthrough_fifo error: read while empty ignored", $time);
            end
        end
    end
`endif
`endif

endmodule

// File: tb/tb_fallthrough_fifo.sv
// Self-checking bench for fallthrough_fifo: directed vector table, async reset and a random stream.
module tb_fallthrough_fifo;

    localparam int W = 72;

    logic         clk = 1'b0;
    logic         reset;
    logic [W-1:0] din;
    logic         wr_en;
    logic         rd_en;
    logic [W-1:0] dout;
    logic         full;
    logic         nearly_full;
    logic         empty;

    int checks = 0;
    int errors = 0;

    fallthrough_fifo dut (
        .clk        (clk),
        .reset      (reset),
        .din        (din),
        .wr_en      (wr_en),
        .rd_en      (rd_en),
        .dout       (dout),
        .full       (full),
        .nearly_full(nearly_full),
        .empty      (empty)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         wr;
        logic         rd;
        logic [W-1:0] din;
        logic         e;
        logic         f;
        logic         nf;
        logic [W-1:0] dout;
    } vec_t;

    vec_t vecs[64];
    int   nvec = 0;

    task automatic add(input logic wr, input logic rd, input logic [W-1:0] d,
                       input logic e, input logic f, input logic nf, input logic [W-1:0] exp_dout);
        vecs[nvec].wr   = wr;
        vecs[nvec].rd   = rd;
        vecs[nvec].din  = d;
        vecs[nvec].e    = e;
        vecs[nvec].f    = f;
        vecs[nvec].nf   = nf;
        vecs[nvec].dout = exp_dout;
        nvec++;
    endtask

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic check_flags(input string name, input logic e, input logic f, input logic nf);
        check({name, ".flags"}, W'({empty, full, nearly_full}), W'({e, f, nf}));
    endtask

    task automatic step(input logic w, input logic r, input logic [W-1:0] d);
        wr_en = w;
        rd_en = r;
        din   = d;
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        rd_en = 1'b0;
    endtask

    initial begin
        int           cnt;
        logic [W-1:0] q[$];
        logic [W-1:0] next_din;
        logic         w;
        logic         r;
        logic         wa;
        logic         ra;

        reset = 1'b1;
        din   = '0;
        wr_en = 1'b0;
        rd_en = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_flags("reset_asserted", 1'b1, 1'b0, 1'b0);
        reset = 1'b0;

        // Directed table: single word, fill/overflow/drain, full write+read, empty corners.
        add(0, 0, '0, 1, 0, 0, '0);
        add(1, 0, W'('hAA), 0, 0, 0, W'('hAA));
        add(0, 1, '0, 1, 0, 0, '0);
        for (int i = 1; i <= 8; i++) add(1, 0, W'(i), 0, i == 8, i >= 7, W'(1));
        add(1, 0, W'(9), 0, 1, 1, W'(1));
        for (int i = 1; i <= 8; i++) add(0, 1, '0, i == 8, 0, i == 1, W'(i + 1));
        for (int i = 1; i <= 8; i++) add(1, 0, W'(i), 0, i == 8, i >= 7, W'(1));
        add(1, 1, W'('h10), 0, 1, 1, W'(2));
        for (int k = 1; k <= 8; k++) add(0, 1, '0, k == 8, 0, k == 1, (k <= 6) ? W'(k + 2) : W'('h10));
        add(1, 1, W'('h20), 0, 0, 0, W'('h20));
        add(0, 1, '0, 1, 0, 0, '0);
        add(0, 1, '0, 1, 0, 0, '0);
        add(0, 0, '0, 1, 0, 0, '0);

        for (int i = 0; i < nvec; i++) begin
            step(vecs[i].wr, vecs[i].rd, vecs[i].din);
            check_flags($sformatf("vec%0d", i), vecs[i].e, vecs[i].f, vecs[i].nf);
            if (!vecs[i].e) check($sformatf("vec%0d.dout", i), dout, vecs[i].dout);
        end

        // Asynchronous reset with three words stored, sampled before the next clock edge.
        for (int i = 0; i < 3; i++) step(1, 0, W'('h30 + i));
        check_flags("pre_async_reset", 1'b0, 1'b0, 1'b0);
        #2 reset = 1'b1;
        #1;
        check_flags("async_reset", 1'b1, 1'b0, 1'b0);
        #2 reset = 1'b0;
        @(posedge clk);
        #1;
        check_flags("after_async_reset", 1'b1, 1'b0, 1'b0);

        // Random stream against a queue model, write-heavy then read-heavy.
        cnt      = 0;
        next_din = W'('h100);
        for (int c = 0; c < 120; c++) begin
            if (c < 60) begin
                w = ($urandom_range(0, 3) != 0);
                r = ($urandom_range(0, 3) == 0);
            end else begin
                w = ($urandom_range(0, 3) == 0);
                r = ($urandom_range(0, 3) != 0);
            end
            wa = w && (cnt < 8 || r);
            ra = r && (cnt > 0);
            step(w, r, next_din);
            if (ra) void'(q.pop_front());
            if (wa) begin
                q.push_back(next_din);
                next_din = next_din + 1'b1;
            end
            cnt = q.size();
            check_flags($sformatf("rand%0d", c), cnt == 0, cnt == 8, cnt >= 7);
            if (cnt > 0) check($sformatf("rand%0d.dout", c), dout, q[0]);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
